// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game sequencer: flap button debounce, IDLE/PLAY/DEAD FSM, best score.
// Optional: GAME_FLOW_AUTO_RESTART_EN leaves DEAD automatically once the hold time expires.

module game_flow_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int DEAD_HOLD_MS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       isDead,
  input  logic [7:0] score,
  output logic [1:0] state,
  output logic       up_button,
  output logic       flap_pulse,
  output logic [7:0] best_score,
  output logic       new_best
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(DEAD_HOLD_MS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(DEAD_HOLD_MS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  state_t          st_q;
  logic            btn_meta;
  logic            btn_s;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [DW-1:0]   db_cnt;
  logic            up_button_q;
  logic            press;
  logic [HW-1:0]   hold_cnt;
  logic            hold_done;

  assign state     = st_q;
  assign tick      = (tick_cnt == TICK_LAST);
  assign press     = up_button & ~up_button_q;
  assign hold_done = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A new level is accepted only after DEBOUNCE_MS consecutive mismatched ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt      <= '0;
      up_button   <= 1'b0;
      up_button_q <= 1'b0;
    end else begin
      up_button_q <= up_button;
      if (tick) begin
        if (btn_s != up_button) begin
          if (db_cnt == DB_LAST) begin
            up_button <= btn_s;
            db_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      flap_pulse <= 1'b0;
      best_score <= 8'd0;
      new_best   <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      flap_pulse <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (press) begin
            st_q       <= ST_PLAY;
            flap_pulse <= 1'b1;
            new_best   <= 1'b0;
          end
        end
        ST_PLAY: begin
          // Death takes priority over a coincident press.
          if (isDead) begin
            st_q     <= ST_DEAD;
            hold_cnt <= '0;
            if (score > best_score) begin
              best_score <= score;
              new_best   <= 1'b1;
            end else begin
              new_best <= 1'b0;
            end
          end else if (press) begin
            flap_pulse <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (tick && !hold_done) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
`ifdef GAME_FLOW_AUTO_RESTART_EN
          if (hold_done) begin
            st_q     <= ST_IDLE;
            new_best <= 1'b0;
          end
`else
          if (hold_done && press) begin
            st_q     <= ST_IDLE;
            new_best <= 1'b0;
          end
`endif
        end
        default: begin
          st_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed bench for game_flow_ctrl (TICK_DIV=4, DEBOUNCE_MS=3, DEAD_HOLD_MS=5).

module tb_game_flow_ctrl;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       btn_raw = 1'b0;
  logic       isDead  = 1'b0;
  logic [7:0] score   = 8'd0;
  logic [1:0] state;
  logic       up_button;
  logic       flap_pulse;
  logic [7:0] best_score;
  logic       new_best;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .TICK_DIV    (4),
    .DEBOUNCE_MS (3),
    .DEAD_HOLD_MS(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .isDead    (isDead),
    .score     (score),
    .state     (state),
    .up_button (up_button),
    .flap_pulse(flap_pulse),
    .best_score(best_score),
    .new_best  (new_best)
  );

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_press(output int flaps);
    int n;
    flaps = 0;
    btn_raw = 1'b1;
    n = 0;
    while (up_button !== 1'b1 && n < 40) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) flaps++;
      n++;
    end
    checks++;
    if (up_button !== 1'b1) begin
      errors++;
      $display("FAIL press_timeout up_button=%b required 1", up_button);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) flaps++;
    end
    btn_raw = 1'b0;
    n = 0;
    while (up_button !== 1'b0 && n < 40) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) flaps++;
      n++;
    end
    checks++;
    if (up_button !== 1'b0) begin
      errors++;
      $display("FAIL release_timeout up_button=%b required 0", up_button);
    end
  endtask

  task automatic die_with(input logic [7:0] s);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL die_from_play state=%0d required 1", state);
    end
    score  = s;
    isDead = 1'b1;
    @(negedge clk);
    isDead = 1'b0;
  endtask

  task automatic leave_dead();
    int f;
    wait_clks(30);
`ifndef GAME_FLOW_AUTO_RESTART_EN
    do_press(f);
`else
    f = 0;
`endif
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL leave_dead_state state=%0d required 0", state);
    end
    checks++;
    if (f !== 0) begin
      errors++;
      $display("FAIL leave_dead_flaps flaps=%0d required 0", f);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state state=%0d required 0", state); end
    checks++;
    if (up_button !== 1'b0) begin errors++; $display("FAIL reset_up_button got=%b required 0", up_button); end
    checks++;
    if (flap_pulse !== 1'b0) begin errors++; $display("FAIL reset_flap got=%b required 0", flap_pulse); end
    checks++;
    if (best_score !== 8'd0) begin errors++; $display("FAIL reset_best got=%0d required 0", best_score); end
    checks++;
    if (new_best !== 1'b0) begin errors++; $display("FAIL reset_new_best got=%b required 0", new_best); end
    rst = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_debounce_glitch();
    logic seen;
    seen = 1'b0;
    btn_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= up_button;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen |= up_button;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_up_button seen=%b required 0", seen); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL glitch_state state=%0d required 0", state); end
  endtask

  task automatic test_start();
    int n, f;
    btn_raw = 1'b1;
    n = 0;
    while (up_button !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 11 || n > 14) begin errors++; $display("FAIL debounce_latency clks=%0d required 11..14", n); end
    checks++;
    if (state !== 2'd0 || flap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL start_before state=%0d flap=%b required 0 0", state, flap_pulse);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || flap_pulse !== 1'b1) begin
      errors++;
      $display("FAIL start_edge state=%0d flap=%b required 1 1", state, flap_pulse);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || flap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL start_after state=%0d flap=%b required 1 0", state, flap_pulse);
    end
    f = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
    end
    btn_raw = 1'b0;
    n = 0;
    while (up_button !== 1'b0 && n < 40) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
      n++;
    end
    checks++;
    if (f !== 0) begin errors++; $display("FAIL held_release_flaps flaps=%0d required 0", f); end
  endtask

  task automatic test_flap();
    int f;
    do_press(f);
    checks++;
    if (f !== 1) begin errors++; $display("FAIL second_flap flaps=%0d required 1", f); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL second_flap_state state=%0d required 1", state); end
  endtask

  task automatic test_death_best();
    int f;
    die_with(8'd7);
    checks++;
    if (state !== 2'd2 || best_score !== 8'd7 || new_best !== 1'b1) begin
      errors++;
      $display("FAIL death_first state=%0d best=%0d new_best=%b required 2 7 1", state, best_score, new_best);
    end
    leave_dead();
    do_press(f);
    die_with(8'd7);
    checks++;
    if (state !== 2'd2 || best_score !== 8'd7 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL death_equal state=%0d best=%0d new_best=%b required 2 7 0", state, best_score, new_best);
    end
    leave_dead();
    do_press(f);
    die_with(8'd9);
    checks++;
    if (state !== 2'd2 || best_score !== 8'd9 || new_best !== 1'b1) begin
      errors++;
      $display("FAIL death_higher state=%0d best=%0d new_best=%b required 2 9 1", state, best_score, new_best);
    end
    leave_dead();
  endtask

  task automatic test_hold();
    int n, f, g;
    f = 0;
    btn_raw = 1'b1;
    n = 0;
    while (state !== 2'd1 && n < 60) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
      n++;
    end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL hold_enter_play state=%0d required 1", state); end
    btn_raw = 1'b0;
    n = 0;
    while (up_button !== 1'b0 && n < 40) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
      n++;
    end
    isDead = 1'b1;
    score  = 8'd3;
    @(negedge clk);
    isDead = 1'b0;
    checks++;
    if (state !== 2'd2 || best_score !== 8'd9 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL hold_entry state=%0d best=%0d new_best=%b required 2 9 0", state, best_score, new_best);
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
    end
    checks++;
    if (up_button !== 1'b1) begin errors++; $display("FAIL hold_press_seen up_button=%b required 1", up_button); end
    @(negedge clk);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL hold_press_ignored state=%0d required 2", state); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
    end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL hold_before_expiry state=%0d required 2", state); end
    @(negedge clk);
`ifdef GAME_FLOW_AUTO_RESTART_EN
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL auto_restart state=%0d required 0", state); end
`else
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL hold_no_auto state=%0d required 2", state); end
`endif
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f++;
    end
`ifdef GAME_FLOW_AUTO_RESTART_EN
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL auto_stays_idle state=%0d required 0", state); end
`else
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL held_through_death state=%0d required 2", state); end
`endif
    checks++;
    if (f !== 1) begin errors++; $display("FAIL hold_flaps flaps=%0d required 1", f); end
    btn_raw = 1'b0;
    n = 0;
    while (up_button !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifndef GAME_FLOW_AUTO_RESTART_EN
    do_press(g);
    checks++;
    if (state !== 2'd0 || g !== 0) begin
      errors++;
      $display("FAIL hold_press_exit state=%0d flaps=%0d required 0 0", state, g);
    end
`endif
  endtask

  task automatic test_simultaneous();
    int n, f, f2;
    do_press(f);
    checks++;
    if (state !== 2'd1 || f !== 1) begin
      errors++;
      $display("FAIL simul_start state=%0d flaps=%0d required 1 1", state, f);
    end
    f2 = 0;
    btn_raw = 1'b1;
    n = 0;
    while (up_button !== 1'b1 && n < 40) begin
      @(negedge clk);
      if (flap_pulse === 1'b1) f2++;
      n++;
    end
    isDead = 1'b1;
    score  = 8'd0;
    @(negedge clk);
    isDead = 1'b0;
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL simul_state state=%0d required 2", state); end
    checks++;
    if (flap_pulse !== 1'b0 || f2 !== 0) begin
      errors++;
      $display("FAIL simul_flap flap=%b earlier=%0d required 0 0", flap_pulse, f2);
    end
    checks++;
    if (best_score !== 8'd9) begin errors++; $display("FAIL simul_best best=%0d required 9", best_score); end
    btn_raw = 1'b0;
    n = 0;
    while (up_button !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    leave_dead();
  endtask

  task automatic test_reset_mid();
    int n, f;
    do_press(f);
    checks++;
    if (state !== 2'd1 || best_score !== 8'd9) begin
      errors++;
      $display("FAIL reset_mid_pre state=%0d best=%0d required 1 9", state, best_score);
    end
    btn_raw = 1'b1;
    n = 0;
    while (up_button !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (state !== 2'd0 || best_score !== 8'd0 || flap_pulse !== 1'b0 || up_button !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state=%0d best=%0d flap=%b up=%b required 0 0 0 0",
               state, best_score, flap_pulse, up_button);
    end
    btn_raw = 1'b0;
    wait_clks(4);
  endtask

  initial begin
    test_reset();
    test_debounce_glitch();
    test_start();
    test_flap();
    test_death_best();
    test_hold();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
